// File: rtl/fixed_mul_seq_if.sv
// -----------------------------------------------------------------------------
// fixed_mul_seq_if
//
// This interface carries the operand and result handshakes of fixed_mul_seq.
//
// Signals:
//   in_valid / in_ready   operand pair offered / block can accept
//   in_a, in_b            signed fixed-point multiplicand / multiplier
//   out_valid / out_ready result held / consumer takes result
//   out_data              rounded product, same Q format as the operands
//   out_ovf               product out of range, qualified by out_valid
//   busy                  multiply or normalise in progress
//
// Modports:
//   slave   the multiplier itself
//   master  the producer/consumer driving it
// -----------------------------------------------------------------------------
interface fixed_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/fixed_mul_seq.sv
// -----------------------------------------------------------------------------
// fixed_mul_seq
//
// This is a sequential signed fixed-point multiplier in Q(WIDTH-FRAC).FRAC format.
// The block works on operand magnitudes with a radix-2 shift-add loop, one
// multiplier bit per cycle. It then restores the sign and rounds to nearest,
// with ties going toward +inf. The result is either wrapped or saturated, and
// it is held until the consumer takes it.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (aborts any job in flight)
//   bus   fixed_mul_seq_if.slave (operand/result handshakes, busy)
//
// Build option:
//   FIXED_MUL_SAT_EN  When defined, an overflowing result clamps to the most
//                     positive or most negative code. When undefined, it wraps
//                     (two's complement). out_ovf is identical in both builds.
//
// Timing: the block has a latency of WIDTH+1 cycles from accept to out_valid.
// With out_ready held high, the minimum initiation interval is WIDTH+3 cycles.
// -----------------------------------------------------------------------------
module fixed_mul_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30
) (
  input logic            clk,
  input logic            rst,
  fixed_mul_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;      // full product width
  localparam int RW = 2 * WIDTH + 1;  // rounding headroom
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC - 1);

  typedef enum logic [1:0] {IDLE, RUN, NORM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q;   // |a| << cnt
  logic [WIDTH-1:0] mplier_q;  // |b| >> cnt, so bit 0 is the current bit
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 last_bit;
  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] prod_x, rounded;
  logic                 ovf;
  logic [WIDTH-1:0]     result;

  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). That value still fits as an
  // unsigned WIDTH-bit number.
  assign mag_a    = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
  assign mag_b    = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Restore the sign, then round half-up by adding one half LSB and doing an
  // arithmetic shift (floor).
  always_comb begin
    prod    = sign_q ? -$signed(acc_q) : $signed(acc_q);
    prod_x  = RW'(prod);
    rounded = (prod_x + HALF) >>> FRAC;
    // The result is in range only when every bit from the top down to bit
    // WIDTH-1 is a copy of the sign.
    ovf     = !((&rounded[RW-1:WIDTH-1]) || !(|rounded[RW-1:WIDTH-1]));
`ifdef FIXED_MUL_SAT_EN
    if (ovf)
      result = rounded[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      result = rounded[WIDTH-1:0];
`else
    result = rounded[WIDTH-1:0];
`endif
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default is assigned first so that every path drives state_d.
    // Without it, synthesis would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_bit)      state_d = NORM;
      NORM:                       state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample its pre-edge
    // value. The result therefore does not depend on the order of the
    // processes.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well as the FSM. An aborted job
    // then leaves no stale accumulator, counter or result behind.
    if (rst) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          mcand_q  <= PW'(mag_a);
          mplier_q <= mag_b;
          sign_q   <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        NORM: begin
          out_data_q <= result;
          out_ovf_q  <= ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == RUN) || (state_q == NORM);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fixed_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_fixed_mul_seq
//
// This is the self-checking bench for fixed_mul_seq. It instantiates the block
// twice: a 32-bit Q2.30 instance and a 16-bit Q8.8 instance. Expected results
// come from a reference model that uses plain wide signed arithmetic. The model
// computes the exact product, rounds half up, and then either clamps or wraps.
// -----------------------------------------------------------------------------
module tb_fixed_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_mul_seq_if #(.WIDTH(32)) b32 ();
  fixed_mul_seq_if #(.WIDTH(16)) b16 ();

  fixed_mul_seq #(.WIDTH(32), .FRAC(30)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  fixed_mul_seq #(.WIDTH(16), .FRAC(8))  dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the exact signed product, then floor((p + half) / 2^f).
  // Bit 64 of the return value is ovf; bits 63:0 are the data, masked to w bits.
  function automatic logic [64:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input int f);
    logic signed [127:0] sa, sb, p, r, half, maxv, minv, one;
    logic [63:0] mask, d;
    logic ovf;
    one  = 1;
    sa   = 128'(a) <<< (128 - w);
    sa   = sa >>> (128 - w);
    sb   = 128'(b) <<< (128 - w);
    sb   = sb >>> (128 - w);
    p    = sa * sb;
    half = one <<< (f - 1);
    r    = (p + half) >>> f;
    maxv = (one <<< (w - 1)) - one;
    minv = -(one <<< (w - 1));
    ovf  = (r > maxv) || (r < minv);
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
`ifdef FIXED_MUL_SAT_EN
    if (r > maxv)      d = maxv[63:0];
    else if (r < minv) d = minv[63:0];
    else               d = r[63:0];
`else
    d = r[63:0];
`endif
    return {ovf, d & mask};
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask, v;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = 64'd1 << (w - 1);           // most negative
      1:       v = (64'd1 << (w - 1)) - 64'd1; // most positive
      2:       v = '0;
      3:       v = '1;                         // -1 LSB
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  function automatic logic get_valid(input bit wide);
    return wide ? b32.out_valid : b16.out_valid;
  endfunction
  function automatic logic get_ready(input bit wide);
    return wide ? b32.in_ready : b16.in_ready;
  endfunction
  function automatic logic get_busy(input bit wide);
    return wide ? b32.busy : b16.busy;
  endfunction
  function automatic logic get_ovf(input bit wide);
    return wide ? b32.out_ovf : b16.out_ovf;
  endfunction
  function automatic logic [63:0] get_data(input bit wide);
    return wide ? 64'(b32.out_data) : 64'(b16.out_data);
  endfunction

  task automatic drive_in(input bit wide, input logic v, input logic [63:0] a, input logic [63:0] b);
    if (wide) begin
      b32.in_valid = v; b32.in_a = a[31:0]; b32.in_b = b[31:0];
    end else begin
      b16.in_valid = v; b16.in_a = a[15:0]; b16.in_b = b[15:0];
    end
  endtask

  task automatic set_oready(input bit wide, input logic v);
    if (wide) b32.out_ready = v;
    else      b16.out_ready = v;
  endtask

  // Offer one operand pair and wait (bounded) for the result. Then stall the
  // consumer for `stall` cycles and take the result.
  task automatic do_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                       input int stall, output logic [63:0] d, output logic ovf,
                       output int lat);
    int guard;
    guard = 0;
    while (!get_ready(wide) && guard < 100) begin step(); guard++; end
    if (guard >= 100) check("in_ready timeout", 64'(get_ready(wide)), 64'd1);
    drive_in(wide, 1'b1, a, b);
    step();                                          // accept edge
    drive_in(wide, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    lat = 0;
    while (!get_valid(wide) && lat < 200) begin step(); lat++; end
    d   = get_data(wide);
    ovf = get_ovf(wide);
    repeat (stall) step();
    set_oready(wide, 1'b1);
    step();
    set_oready(wide, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[7];
    logic [63:0] d, d0;
    logic [64:0] m;
    logic        ovf, o0;
    logic [63:0] a, b;
    int          lat, guard, seen;

    tbl[0] = '{32'h40000000, 32'h10000000, 32'h10000000, 1'b0};
    tbl[1] = '{32'hA0000000, 32'h30000000, 32'hB8000000, 1'b0};
`ifdef FIXED_MUL_SAT_EN
    tbl[2] = '{32'hA0000000, 32'hA0000000, 32'h7FFFFFFF, 1'b1};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1};
`else
    tbl[2] = '{32'hA0000000, 32'hA0000000, 32'h90000000, 1'b1};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
`endif
    tbl[3] = '{32'h00000001, 32'h20000000, 32'h00000001, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'h20000000, 32'h00000000, 1'b0};
    tbl[6] = '{32'h40000000, 32'h40000000, 32'h40000000, 1'b0};

    drive_in(1'b1, 1'b0, '0, '0);
    drive_in(1'b0, 1'b0, '0, '0);
    set_oready(1'b1, 1'b0);
    set_oready(1'b0, 1'b0);

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst in_ready",  64'(b32.in_ready),  64'd1);
    check("rst out_valid", 64'(b32.out_valid), 64'd0);
    check("rst out_data",  64'(b32.out_data),  64'd0);
    check("rst out_ovf",   64'(b32.out_ovf),   64'd0);
    check("rst busy",      64'(b32.busy),      64'd0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_op(1'b1, 64'(tbl[i].a), 64'(tbl[i].b), i % 3, d, ovf, lat);
      check($sformatf("tbl%0d data", i), d, 64'(tbl[i].d));
      check($sformatf("tbl%0d ovf", i), 64'(ovf), 64'(tbl[i].ovf));
      check($sformatf("tbl%0d latency", i), 64'(lat), 64'd33);
    end

    // With out_ready held high from before out_valid, out_valid lasts exactly
    // one cycle.
    set_oready(1'b1, 1'b1);
    drive_in(1'b1, 1'b1, 64'h40000000, 64'h10000000);
    step();
    drive_in(1'b1, 1'b0, '0, '0);
    lat = 0;
    while (!b32.out_valid && lat < 200) begin step(); lat++; end
    check("early ready latency", 64'(lat), 64'd33);
    check("early ready data", 64'(b32.out_data), 64'h10000000);
    step();
    check("early ready valid drop", 64'(b32.out_valid), 64'd0);
    check("early ready in_ready", 64'(b32.in_ready), 64'd1);
    set_oready(1'b1, 1'b0);

    // Backpressure: result held, new offers ignored.
    drive_in(1'b1, 1'b1, 64'h40000000, 64'h60000000);
    step();
    drive_in(1'b1, 1'b0, '0, '0);
    guard = 0;
    while (!b32.out_valid && guard < 200) begin step(); guard++; end
    d0 = 64'(b32.out_data);
    o0 = b32.out_ovf;
    check("bp first data", d0, 64'h60000000);
    drive_in(1'b1, 1'b1, 64'h7FFFFFFF, 64'h7FFFFFFF);
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp data stable", 64'(b32.out_data), d0);
      check("bp ovf stable", 64'(b32.out_ovf), 64'(o0));
      check("bp valid held", 64'(b32.out_valid), 64'd1);
      check("bp in_ready low", 64'(b32.in_ready), 64'd0);
    end
    drive_in(1'b1, 1'b1, 64'h20000000, 64'h20000000);
    set_oready(1'b1, 1'b1);
    step();
    set_oready(1'b1, 1'b0);
    check("bp valid drop", 64'(b32.out_valid), 64'd0);
    check("bp in_ready back", 64'(b32.in_ready), 64'd1);
    step();
    drive_in(1'b1, 1'b0, '0, '0);
    check("bp next accepted", 64'(b32.busy), 64'd1);
    guard = 0;
    while (!b32.out_valid && guard < 200) begin step(); guard++; end
    check("bp next data", 64'(b32.out_data), 64'h10000000);
    set_oready(1'b1, 1'b1);
    step();
    set_oready(1'b1, 1'b0);

    // Reset mid-RUN: abort with nothing emitted.
    drive_in(1'b1, 1'b1, 64'h40000000, 64'h30000000);
    step();
    drive_in(1'b1, 1'b0, '0, '0);
    repeat (12) step();
    rst = 1'b1;
    step();
    check("abort busy", 64'(b32.busy), 64'd0);
    check("abort valid", 64'(b32.out_valid), 64'd0);
    check("abort data", 64'(b32.out_data), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (b32.out_valid) seen++;
    end
    check("abort no result", 64'(seen), 64'd0);
    do_op(1'b1, 64'h40000000, 64'h40000000, 0, d, ovf, lat);
    check("after abort data", d, 64'h40000000);
    check("after abort ovf", 64'(ovf), 64'd0);

    // Reset while holding an overflowed result.
    drive_in(1'b1, 1'b1, 64'h80000000, 64'h80000000);
    step();
    drive_in(1'b1, 1'b0, '0, '0);
    guard = 0;
    while (!b32.out_valid && guard < 200) begin step(); guard++; end
    check("hold ovf set", 64'(b32.out_ovf), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hold rst valid", 64'(b32.out_valid), 64'd0);
    check("hold rst ovf", 64'(b32.out_ovf), 64'd0);
    check("hold rst data", 64'(b32.out_data), 64'd0);
    check("hold rst in_ready", 64'(b32.in_ready), 64'd1);

    // Random 32-bit Q2.30 against the model
    for (int i = 0; i < 150; i++) begin
      a = pick(32);
      b = pick(32);
      m = ref_mul(a, b, 32, 30);
      do_op(1'b1, a, b, $urandom_range(0, 3), d, ovf, lat);
      check($sformatf("rnd32 %h*%h data", a[31:0], b[31:0]), d, m[63:0]);
      check($sformatf("rnd32 %h*%h ovf", a[31:0], b[31:0]), 64'(ovf), 64'(m[64]));
      check("rnd32 latency", 64'(lat), 64'd33);
    end

    // 16-bit Q8.8 instance
    do_op(1'b0, 64'h0180, 64'hFF00, 0, d, ovf, lat);
    check("w16 data", d, 64'hFE80);
    check("w16 ovf", 64'(ovf), 64'd0);
    check("w16 latency", 64'(lat), 64'd17);
    check("w16 idle after", 64'(get_busy(1'b0)), 64'd0);
    for (int i = 0; i < 60; i++) begin
      a = pick(16);
      b = pick(16);
      m = ref_mul(a, b, 16, 8);
      do_op(1'b0, a, b, $urandom_range(0, 2), d, ovf, lat);
      check($sformatf("rnd16 %h*%h data", a[15:0], b[15:0]), d, m[63:0]);
      check($sformatf("rnd16 %h*%h ovf", a[15:0], b[15:0]), 64'(ovf), 64'(m[64]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
